eth_rx_frame_buffer: RTL and testbench
======================================

Name: eth_rx_frame_buffer

Overview:
- Store-and-forward ingress buffer between a MAC receive stream and switch port 0 of ethernet_packet_switch. It drives the rx_*_0 inputs.
- Accepts word-wide frames marked with sop/eop/bv. It discards malformed, overflowing and, optionally, runt frames.
- It only forwards complete, committed frames, as contiguous one-word-per-cycle bursts with no backpressure.

Parameters:
- DATA_W, 32: data word width in bits; must be a multiple of 8.
- BV_W, 2: byte-valid width, equal to log2(DATA_W/8).
- DEPTH, 512: FIFO depth in words; power of 2, minimum 16.
- MIN_WORDS, 16: minimum frame length in words. Used only with RUNT_FILTER_EN.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-low reset.
- in_data  in  DATA_W  MAC receive data.
- in_bv  in  BV_W  valid bytes in the eop word; 0 means all bytes valid. Ignored on non-eop words.
- in_sop  in  1  first word of frame; qualified by in_valid.
- in_eop  in  1  last word of frame; qualified by in_valid.
- in_valid  in  1  word valid.
- out_data  out  DATA_W  to switch rx_data_0.
- out_bv  out  BV_W  to rx_bv_0.
- out_sop  out  1  to rx_sop_0.
- out_eop  out  1  to rx_eop_0.
- out_valid  out  1  to rx_valid_0.
- drop_cnt  out  16  dropped-frame counter; saturates at 0xFFFF.
- level  out  log2(DEPTH)+1  words currently held, committed plus partial.

Behaviour:
- Reset (reset==0 at a clock edge):
  - Pointers, frame count, level, drop_cnt, write-FSM and read-FSM are all cleared.
  - All out_* are 0 after that edge.
  - Partial and committed frames are lost.
  - Reset asserted mid-burst truncates the output immediately; no eop is emitted.
- Storage:
  - Each entry holds {data, bv, eop}.
  - Pointers wr_ptr, wr_base (start of the uncommitted frame) and rd_ptr are log2(DEPTH)+1 bits, with wrap-around by MSB toggle.
  - full means wr_ptr - rd_ptr == DEPTH.
- Write FSM, states W_IDLE, W_FRAME, W_DISCARD:
  - W_IDLE, valid&sop: write the word at wr_base and go to W_FRAME. If sop&eop together, it is a one-word frame: write and commit, stay in W_IDLE.
  - W_IDLE, valid without sop: discard the word silently; drop_cnt is unchanged.
  - W_FRAME, valid&!sop&!eop: write.
  - W_FRAME, valid&eop: write, commit (wr_base<=wr_ptr+1, frame_cnt+1), go to W_IDLE.
  - W_FRAME, valid&sop: protocol error. Rewind wr_ptr to wr_base, drop_cnt+1, and treat the word as a new sop in the same cycle.
  - Any write attempted while full: rewind wr_ptr to wr_base, drop_cnt+1, go to W_DISCARD. A frame longer than DEPTH is therefore always dropped.
  - W_DISCARD: ignore words until valid&eop, then go to W_IDLE. A sop seen in W_DISCARD starts a new frame, as in W_IDLE.
- Read FSM, states R_IDLE, R_SEND:
  - R_IDLE with frame_cnt>0: read the word at rd_ptr into the output registers with out_sop=1 and go to R_SEND.
  - R_SEND: output one word per cycle, with out_valid held high continuously.
  - out_eop and out_bv come from the stored entry. out_bv is forced to 0 on non-eop words.
  - On the eop word, frame_cnt decrements. If another frame is committed, its sop follows in the very next cycle; otherwise go to R_IDLE and out_valid=0.
- Latency: eop presented in cycle k gives out_sop/out_valid in cycle k+2, when the read FSM is idle.
- Simultaneous events: a commit and a read-frame completion in the same cycle leave frame_cnt unchanged. A write and a read in the same cycle are always allowed; full is evaluated before the read.
- Level equals wr_ptr - rd_ptr. Rewound words free their space in the cycle after the rewind.
- drop_cnt increments at most once per dropped frame and holds at 0xFFFF.

Optional Feature:
- Macro RUNT_FILTER_EN.
- Defined:
  - A per-frame word counter is kept.
  - An eop arriving with fewer than MIN_WORDS words (including the eop word) rewinds instead of committing, and drop_cnt+1.
  - A one-word sop&eop frame counts as length 1.
- Undefined: no length counter exists, MIN_WORDS is unused, and every well-formed frame is committed.

Test Plan:
- 20-word frame, data 0x0000_0001..0x0000_0014, eop bv=2 in cycle k -> out_sop in cycle k+2, 20 contiguous valid words with identical data, out_eop on word 20 with out_bv=2, drop_cnt=0, level returns to 0.
- Three 18-word frames back-to-back on input -> three output frames with no idle cycle between them (eop followed immediately by sop), in order.
- sop, 5 words, then a second sop and 17 words + eop -> only the 18-word frame is output, drop_cnt=1.
- DEPTH=16, 20-word frame followed by a 16-word frame -> the first is dropped (drop_cnt=1), the second is fully delivered, and level never exceeds 16.
- Assert reset for one cycle during word 8 of an output burst -> all out_* 0 the next cycle, level=0, drop_cnt=0, and a following 16-word frame passes correctly.
- With RUNT_FILTER_EN and MIN_WORDS=16: 15-word frame -> dropped, drop_cnt=1; 16-word frame -> delivered. Without the macro, both are delivered.

Source files
------------

// File: rtl/eth_rx_frame_buffer.sv
// Store-and-forward ingress buffer: commits whole frames, forwards them as contiguous bursts.
// Define RUNT_FILTER_EN to also drop frames shorter than MIN_WORDS words.
module eth_rx_frame_buffer #(
  parameter int DATA_W    = 32,
  parameter int BV_W      = 2,
  parameter int DEPTH     = 512,
  parameter int MIN_WORDS = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DATA_W-1:0]      in_data,
  input  logic [BV_W-1:0]        in_bv,
  input  logic                   in_sop,
  input  logic                   in_eop,
  input  logic                   in_valid,
  output logic [DATA_W-1:0]      out_data,
  output logic [BV_W-1:0]        out_bv,
  output logic                   out_sop,
  output logic                   out_eop,
  output logic                   out_valid,
  output logic [15:0]            drop_cnt,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);
  localparam int EW = DATA_W + BV_W + 1;
  localparam logic [AW:0] DEPTH_L = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_FRAME = 2'd1, W_DISCARD = 2'd2} wstate_t;
  typedef enum logic {R_IDLE = 1'b0, R_SEND = 1'b1} rstate_t;

  function automatic logic [15:0] sat_add(input logic [15:0] cnt, input logic [1:0] inc);
    logic [16:0] sum;
    sum = {1'b0, cnt} + {15'd0, inc};
    if (sum[16]) sat_add = 16'hFFFF;
    else         sat_add = sum[15:0];
  endfunction

  logic [EW-1:0]     mem_r [DEPTH];
  logic [AW:0]       wr_ptr_r, wr_base_r, rd_ptr_r, frame_cnt_r;
  logic [AW:0]       wr_ptr_s, wr_base_s;
  logic [AW-1:0]     waddr_s;
  logic [15:0]       drop_cnt_r;
  logic [1:0]        drop_inc_s;
  wstate_t           wstate_r, wstate_s;
  rstate_t           rstate_r, rstate_s;
  logic              we_s, commit_s, start_s, finish_s, full_s, full_base_s;
  logic              rd_en_s, rd_sop_s, rd_done_s, clear_s;
  logic [EW-1:0]     wr_entry_s, rd_entry_s;
  logic [DATA_W-1:0] out_data_r;
  logic [BV_W-1:0]   out_bv_r;
  logic              out_sop_r, out_eop_r, out_valid_r;
`ifdef RUNT_FILTER_EN
  localparam logic [AW+1:0] MIN_L = (AW+2)'(MIN_WORDS);
  localparam logic [AW+1:0] LEN_ONE = {{(AW+1){1'b0}}, 1'b1};
  logic [AW+1:0] wcnt_r, wcnt_s, eop_len_s;
`endif

  // bv is kept only on the eop word so the read side needs no masking
  assign wr_entry_s  = {in_data, (in_eop ? in_bv : {BV_W{1'b0}}), in_eop};
  assign rd_entry_s  = mem_r[rd_ptr_r[AW-1:0]];
  assign full_s      = (wr_ptr_r - rd_ptr_r) == DEPTH_L;
  assign full_base_s = (wr_base_r - rd_ptr_r) == DEPTH_L;
  assign rd_done_s   = rd_en_s & rd_entry_s[0];

  assign out_data  = out_data_r;
  assign out_bv    = out_bv_r;
  assign out_sop   = out_sop_r;
  assign out_eop   = out_eop_r;
  assign out_valid = out_valid_r;
  assign drop_cnt  = drop_cnt_r;
  assign level     = wr_ptr_r - rd_ptr_r;

  // frame storage write port
  always_ff @(posedge clk) begin
    if (we_s) mem_r[waddr_s] <= wr_entry_s;
  end

  // write FSM: a stray sop restarts at wr_base, and overflow rewinds then discards the rest
  always_comb begin
    wstate_s   = wstate_r;
    we_s       = 1'b0;
    waddr_s    = wr_ptr_r[AW-1:0];
    wr_ptr_s   = wr_ptr_r;
    wr_base_s  = wr_base_r;
    commit_s   = 1'b0;
    drop_inc_s = 2'd0;
    start_s    = 1'b0;
    finish_s   = 1'b0;
`ifdef RUNT_FILTER_EN
    wcnt_s     = wcnt_r;
    eop_len_s  = wcnt_r + LEN_ONE;
`endif
    if (in_valid) begin
      case (wstate_r)
        W_FRAME: begin
          if (in_sop) begin
            wr_ptr_s   = wr_base_r;
            drop_inc_s = 2'd1;
            start_s    = 1'b1;
          end else if (full_s) begin
            wr_ptr_s   = wr_base_r;
            drop_inc_s = 2'd1;
            wstate_s   = in_eop ? W_IDLE : W_DISCARD;
          end else begin
            we_s     = 1'b1;
            wr_ptr_s = wr_ptr_r + PTR_ONE;
            finish_s = in_eop;
`ifdef RUNT_FILTER_EN
            wcnt_s   = eop_len_s;
`endif
          end
        end
        W_IDLE, W_DISCARD: begin
          if (in_sop)      start_s  = 1'b1;
          else if (in_eop) wstate_s = W_IDLE;
          else             wstate_s = wstate_r;
        end
        default: wstate_s = W_IDLE;
      endcase
    end else begin
      wstate_s = wstate_r;
    end

    if (start_s) begin
      if (full_base_s) begin
        wr_ptr_s   = wr_base_r;
        drop_inc_s = drop_inc_s + 2'd1;
        wstate_s   = in_eop ? W_IDLE : W_DISCARD;
      end else begin
        we_s     = 1'b1;
        waddr_s  = wr_base_r[AW-1:0];
        wr_ptr_s = wr_base_r + PTR_ONE;
        wstate_s = W_FRAME;
        finish_s = in_eop;
`ifdef RUNT_FILTER_EN
        wcnt_s    = LEN_ONE;
        eop_len_s = LEN_ONE;
`endif
      end
    end else begin
      start_s = 1'b0;
    end

    if (finish_s) begin
      wstate_s = W_IDLE;
`ifdef RUNT_FILTER_EN
      if (eop_len_s < MIN_L) begin
        wr_ptr_s   = wr_base_r;
        drop_inc_s = drop_inc_s + 2'd1;
      end else begin
        commit_s  = 1'b1;
        wr_base_s = wr_ptr_s;
      end
`else
      commit_s  = 1'b1;
      wr_base_s = wr_ptr_s;
`endif
    end else begin
      commit_s = 1'b0;
    end
  end

  // read FSM: after an eop word, the next committed frame's sop follows immediately
  always_comb begin
    rstate_s = rstate_r;
    rd_en_s  = 1'b0;
    rd_sop_s = 1'b0;
    clear_s  = 1'b0;
    case (rstate_r)
      R_IDLE: begin
        if (frame_cnt_r != {(AW+1){1'b0}}) begin
          rd_en_s  = 1'b1;
          rd_sop_s = 1'b1;
          rstate_s = R_SEND;
        end else begin
          rstate_s = R_IDLE;
        end
      end
      R_SEND: begin
        if (!out_eop_r) begin
          rd_en_s = 1'b1;
        end else if (frame_cnt_r != {(AW+1){1'b0}}) begin
          rd_en_s  = 1'b1;
          rd_sop_s = 1'b1;
        end else begin
          clear_s  = 1'b1;
          rstate_s = R_IDLE;
        end
      end
      default: begin
        clear_s  = 1'b1;
        rstate_s = R_IDLE;
      end
    endcase
  end

  // pointers, counters, FSM state and output registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      wstate_r    <= W_IDLE;
      rstate_r    <= R_IDLE;
      wr_ptr_r    <= {(AW+1){1'b0}};
      wr_base_r   <= {(AW+1){1'b0}};
      rd_ptr_r    <= {(AW+1){1'b0}};
      frame_cnt_r <= {(AW+1){1'b0}};
      drop_cnt_r  <= 16'd0;
      out_data_r  <= {DATA_W{1'b0}};
      out_bv_r    <= {BV_W{1'b0}};
      out_sop_r   <= 1'b0;
      out_eop_r   <= 1'b0;
      out_valid_r <= 1'b0;
`ifdef RUNT_FILTER_EN
      wcnt_r      <= {(AW+2){1'b0}};
`endif
    end else begin
      wstate_r   <= wstate_s;
      rstate_r   <= rstate_s;
      wr_ptr_r   <= wr_ptr_s;
      wr_base_r  <= wr_base_s;
      drop_cnt_r <= sat_add(drop_cnt_r, drop_inc_s);
`ifdef RUNT_FILTER_EN
      wcnt_r     <= wcnt_s;
`endif
      case ({commit_s, rd_done_s})
        2'b10:   frame_cnt_r <= frame_cnt_r + PTR_ONE;
        2'b01:   frame_cnt_r <= frame_cnt_r - PTR_ONE;
        default: frame_cnt_r <= frame_cnt_r;
      endcase
      if (rd_en_s) begin
        out_data_r  <= rd_entry_s[EW-1 -: DATA_W];
        out_bv_r    <= rd_entry_s[BV_W:1];
        out_eop_r   <= rd_entry_s[0];
        out_sop_r   <= rd_sop_s;
        out_valid_r <= 1'b1;
        rd_ptr_r    <= rd_ptr_r + PTR_ONE;
      end else if (clear_s) begin
        out_data_r  <= {DATA_W{1'b0}};
        out_bv_r    <= {BV_W{1'b0}};
        out_eop_r   <= 1'b0;
        out_sop_r   <= 1'b0;
        out_valid_r <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_eth_rx_frame_buffer.sv
// Randomized and directed bench for eth_rx_frame_buffer against a queue-based frame model.
module tb_eth_rx_frame_buffer;
  localparam int DATA_W = 32, BV_W = 2, DEPTH = 32, MIN_WORDS = 16;

  logic clk = 1'b0;
  logic reset;
  logic [DATA_W-1:0] in_data;
  logic [BV_W-1:0] in_bv;
  logic in_sop, in_eop, in_valid;
  logic [DATA_W-1:0] out_data;
  logic [BV_W-1:0] out_bv;
  logic out_sop, out_eop, out_valid;
  logic [15:0] drop_cnt;
  logic [$clog2(DEPTH):0] level;

  always #5 clk = ~clk;

  eth_rx_frame_buffer #(.DATA_W(DATA_W), .BV_W(BV_W), .DEPTH(DEPTH), .MIN_WORDS(MIN_WORDS)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_bv(in_bv), .in_sop(in_sop),
    .in_eop(in_eop), .in_valid(in_valid), .out_data(out_data), .out_bv(out_bv),
    .out_sop(out_sop), .out_eop(out_eop), .out_valid(out_valid), .drop_cnt(drop_cnt), .level(level));

  typedef struct { logic [31:0] d; logic [1:0] b; logic e; } word_t;

  // model: committed words awaiting output, the partial frame, and the expected output word
  word_t cq[$];
  word_t cur[$];
  int nframes = 0, mode = 0, drops = 0;
  logic ev = 1'b0, es = 1'b0, ee = 1'b0;
  logic [31:0] ed = 32'd0;
  logic [1:0] eb = 2'd0;
  bit live = 1'b0;

  int checks = 0, failures = 0, cyc = 0;
  int frames_out = 0, run = 0, max_run = 0, blen = 0, last_blen = 0, max_lvl = 0;
  int last_sop_cyc = 0, eop_cyc = 0;
  logic [31:0] last_eop_data = 32'd0;
  logic [1:0] last_eop_bv = 2'd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic m_finish();
    bit runt;
    runt = 1'b0;
`ifdef RUNT_FILTER_EN
    runt = (cur.size() < MIN_WORDS);
`endif
    if (runt) drops++;
    else begin
      foreach (cur[i]) cq.push_back(cur[i]);
      nframes++;
    end
    cur.delete();
    mode = 0;
  endtask

  task automatic m_start(input word_t w, input int cqs);
    cur.delete();
    if (cqs == DEPTH) begin
      drops++;
      mode = w.e ? 0 : 2;
    end else begin
      cur.push_back(w);
      mode = 1;
      if (w.e) m_finish();
    end
  endtask

  task automatic m_pop(input logic sop);
    word_t w;
    if (cq.size() == 0) begin
      ev = 1'b0; es = 1'b0; ee = 1'b0; ed = 32'd0; eb = 2'd0;
    end else begin
      w = cq.pop_front();
      ev = 1'b1; es = sop; ee = w.e; ed = w.d;
      eb = w.e ? w.b : 2'd0;
      if (w.e) nframes--;
    end
  endtask

  task automatic model_step(input logic v, input logic s, input logic e,
                            input logic [31:0] d, input logic [1:0] b, input logic r);
    word_t w;
    int cqs, occ;
    if (!r) begin
      cq.delete(); cur.delete();
      nframes = 0; mode = 0; drops = 0;
      ev = 1'b0; es = 1'b0; ee = 1'b0; ed = 32'd0; eb = 2'd0;
      return;
    end
    cqs = cq.size();
    occ = cqs + cur.size();
    if (nframes > 0 && (!ev || ee)) m_pop(1'b1);
    else if (ev && !ee) m_pop(1'b0);
    else begin
      ev = 1'b0; es = 1'b0; ee = 1'b0; ed = 32'd0; eb = 2'd0;
    end
    w.d = d; w.b = b; w.e = e;
    if (v) begin
      if (mode == 1) begin
        if (s) begin
          drops++;
          m_start(w, cqs);
        end else if (occ == DEPTH) begin
          drops++;
          cur.delete();
          mode = e ? 0 : 2;
        end else begin
          cur.push_back(w);
          if (e) m_finish();
        end
      end else if (s) m_start(w, cqs);
      else if (e) mode = 0;
    end
  endtask

  // per-cycle comparison against the model, plus burst bookkeeping for directed checks
  always @(negedge clk) begin
    if (live) begin
      chk("out_valid", 32'(out_valid), 32'(ev));
      if (ev) begin
        chk("out_sop", 32'(out_sop), 32'(es));
        chk("out_eop", 32'(out_eop), 32'(ee));
        chk("out_data", out_data, ed);
        chk("out_bv", 32'(out_bv), 32'(eb));
      end
      chk("level", 32'(level), 32'(cq.size() + cur.size()));
      chk("drop_cnt", 32'(drop_cnt), 32'((drops > 65535) ? 65535 : drops));
      if (out_valid) begin
        run++;
        if (out_sop) begin blen = 1; last_sop_cyc = cyc; end
        else blen++;
        if (out_eop) begin
          frames_out++; last_blen = blen; last_eop_data = out_data; last_eop_bv = out_bv;
        end
      end else run = 0;
      if (run > max_run) max_run = run;
      if (int'(level) > max_lvl) max_lvl = int'(level);
    end
  end

  task automatic cyc_drive(input logic v, input logic s, input logic e,
                           input logic [31:0] d, input logic [1:0] b, input logic r);
    in_valid = v; in_sop = s; in_eop = e; in_data = d; in_bv = b; reset = r;
    @(posedge clk);
    model_step(v, s, e, d, b, r);
    if (!r) live = 1'b1;
    #1;
  endtask

  task automatic idle();
    cyc_drive(1'b0, 1'($urandom), 1'($urandom), $urandom, 2'($urandom), 1'b1);
  endtask

  task automatic send_frame(input int len, input logic [31:0] base, input logic [1:0] bv,
                            input bit eop_en, input int bub);
    for (int i = 0; i < len; i++) begin
      while ($urandom_range(99) < bub) idle();
      if (i == len - 1)
        cyc_drive(1'b1, i == 0, eop_en, base + 32'(i), bv, 1'b1);
      else
        cyc_drive(1'b1, i == 0, 1'b0, base + 32'(i), 2'($urandom), 1'b1);
      if (i == len - 1) eop_cyc = cyc - 1;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    idle();
    while ((cq.size() != 0 || ev) && n < 400) begin
      idle();
      n++;
    end
    chk("drain_done", 32'(n < 400), 32'd1);
  endtask

  initial begin
    int f0, n;
    repeat (3) cyc_drive(1'b0, 1'b0, 1'b0, 32'd0, 2'd0, 1'b0);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_sop", 32'(out_sop), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);

    // single 20-word frame with fixed data
    drain();
    f0 = frames_out;
    send_frame(20, 32'd1, 2'd2, 1'b1, 0);
    drain();
    chk("t1_latency", 32'(last_sop_cyc - eop_cyc), 32'd2);
    chk("t1_frames", 32'(frames_out - f0), 32'd1);
    chk("t1_len", 32'(last_blen), 32'd20);
    chk("t1_eop_data", last_eop_data, 32'd20);
    chk("t1_eop_bv", 32'(last_eop_bv), 32'd2);
    chk("t1_drop", 32'(drop_cnt), 32'd0);
    chk("t1_level", 32'(level), 32'd0);

    // three back-to-back 18-word frames form one unbroken burst
    max_run = 0;
    f0 = frames_out;
    for (int k = 1; k <= 3; k++) send_frame(18, 32'(100 * k), 2'd1, 1'b1, 0);
    drain();
    chk("t2_run", 32'(max_run), 32'd54);
    chk("t2_frames", 32'(frames_out - f0), 32'd3);

    // truncated frame interrupted by a new sop
    f0 = frames_out;
    send_frame(5, 32'd200, 2'd0, 1'b0, 0);
    send_frame(18, 32'd300, 2'd3, 1'b1, 0);
    drain();
    chk("t3_drop", 32'(drop_cnt), 32'd1);
    chk("t3_frames", 32'(frames_out - f0), 32'd1);
    chk("t3_len", 32'(last_blen), 32'd18);
    chk("t3_eop_data", last_eop_data, 32'd317);

    // oversize frame, then a normal one
    max_lvl = 0;
    f0 = frames_out;
    send_frame(40, 32'd400, 2'd1, 1'b1, 0);
    send_frame(16, 32'd500, 2'd2, 1'b1, 0);
    drain();
    chk("t4_drop", 32'(drop_cnt), 32'd2);
    chk("t4_frames", 32'(frames_out - f0), 32'd1);
    chk("t4_max_level", 32'(max_lvl), 32'(DEPTH));
    chk("t4_len", 32'(last_blen), 32'd16);

    // reset during word 8 of an output burst
    send_frame(16, 32'd600, 2'd1, 1'b1, 0);
    n = 0;
    while (!(out_valid && out_sop) && n < 20) begin idle(); n++; end
    chk("t5_sop_seen", 32'(n < 20), 32'd1);
    repeat (7) idle();
    chk("t5_word8", out_data, 32'd607);
    cyc_drive(1'b0, 1'b0, 1'b0, 32'd0, 2'd0, 1'b0);
    @(negedge clk);
    chk("t5_valid", 32'(out_valid), 32'd0);
    chk("t5_sop", 32'(out_sop), 32'd0);
    chk("t5_eop", 32'(out_eop), 32'd0);
    chk("t5_data", out_data, 32'd0);
    chk("t5_level", 32'(level), 32'd0);
    chk("t5_drop", 32'(drop_cnt), 32'd0);
    f0 = frames_out;
    send_frame(16, 32'd700, 2'd3, 1'b1, 0);
    drain();
    chk("t5_frames", 32'(frames_out - f0), 32'd1);
    chk("t5_eop_data", last_eop_data, 32'd715);

    // 15-word and 16-word frames
    f0 = frames_out;
    send_frame(15, 32'd800, 2'd1, 1'b1, 0);
    send_frame(16, 32'd900, 2'd1, 1'b1, 0);
    drain();
`ifdef RUNT_FILTER_EN
    chk("t6_drop", 32'(drop_cnt), 32'd1);
    chk("t6_frames", 32'(frames_out - f0), 32'd1);
`else
    chk("t6_drop", 32'(drop_cnt), 32'd0);
    chk("t6_frames", 32'(frames_out - f0), 32'd2);
`endif
    chk("t6_len", 32'(last_blen), 32'd16);

    // random traffic with bubbles, missing eops and stray words
    for (int f = 0; f < 200; f++) begin
      if ($urandom_range(99) < 4)
        cyc_drive(1'b1, 1'b0, 1'($urandom), $urandom, 2'($urandom), 1'b1);
      send_frame($urandom_range(1, 40), $urandom, 2'($urandom), $urandom_range(99) >= 6, 20);
      repeat ($urandom_range(0, 3)) idle();
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, failures=%0d", failures);
    $fatal(1);
  end
endmodule
